io_tx_serializer: RTL and testbench
===================================

Name: io_tx_serializer

Overview:
- Transmit-side parallel-to-serial gearbox for the genesis3 IO path; the output-direction counterpart of the input buffer/deserializer path.
- Accepts a WIDTH-bit word from fabric via a valid/ready handshake and shifts it out one bit per CLK.
- Produces serial data plus a registered tristate enable, so both feed an O_BUFT cell directly (T=1 drives the pad).

Parameters:
- WIDTH, 4, bits per word; legal range 3..10.
- IDLE_VALUE, 1'b0, level driven on Q when no word is in flight.

Ports:
- CLK  input  1  fabric/IO clock; all state updates on the rising edge.
- RST  input  1  asynchronous, active-low reset.
- D  input  WIDTH  parallel word; bit 0 is transmitted first.
- DATA_VALID  input  1  D holds a valid word.
- READY  output  1  block accepts D this cycle.
- OE_IN  input  1  per-word output enable; sampled with D.
- Q  output  1  serial data to the O_BUFT I pin.
- T_OUT  output  1  tristate control to the O_BUFT T pin (1 = drive).
- BUSY  output  1  a word is being shifted.

Behaviour:
- Reset (RST=0, asynchronous): state=IDLE, shift register=0, bit counter=0, Q=IDLE_VALUE, T_OUT=0, BUSY=0. READY=1 combinationally after reset release.
- States:
  - IDLE: READY=1. Accept on an edge with DATA_VALID&READY, then go to SHIFT.
  - SHIFT: counter runs 0..WIDTH-1.
- Handshake: a transfer occurs on a rising edge where DATA_VALID=1 and READY=1. D and OE_IN are captured on that edge.
- READY = (state==IDLE) | (state==SHIFT & counter==WIDTH-1). READY is combinational from registers only, never from DATA_VALID.
- Latency:
  - Word accepted at edge N: Q=D[0] from edge N, then D[i] from edge N+i.
  - T_OUT=OE_IN(captured) from edge N through edge N+WIDTH-1.
  - All outputs are registered.
- Back-to-back: a transfer at the last-bit edge loads the new word and restarts the counter at 0. Q and T_OUT run gapless across the word boundary.
- End of word with no transfer: at the edge after the last bit, go to IDLE, Q=IDLE_VALUE, T_OUT=0, BUSY=0.
- BUSY=1 whenever state==SHIFT.
- DATA_VALID while READY=0: ignored. D may change freely; the source must hold it until accepted.
- Counter width: ceil(log2(WIDTH+1)). No wrap beyond WIDTH-1; the counter returns to 0 only on load or on the transition to IDLE.
- Reset mid-word: the word is discarded, outputs go to reset values immediately (asynchronous), and no partial completion occurs after release.
- OE_IN=0 word: bits still shift internally and Q still toggles, but T_OUT=0 for the whole word (pad tristated). Timing is otherwise unchanged.

Optional Feature:
- IO_TX_PARITY_EN defined:
  - Each word is followed by one even-parity bit (XOR of D) on Q. The frame is WIDTH+1 cycles.
  - T_OUT stays at the captured OE_IN during the parity cycle.
  - READY is asserted during the parity cycle instead of at bit WIDTH-1.
  - The counter runs 0..WIDTH.
- Undefined: no parity cycle; frame is WIDTH cycles exactly as above.

Test Plan:
- Reset: hold RST=0 two cycles with DATA_VALID=1, D=4'hF -> Q=0, T_OUT=0, BUSY=0 throughout. READY=1 after release; no transfer while RST=0.
- Single word: WIDTH=4, D=4'b1011, OE_IN=1, one-cycle valid at edge N -> Q=1,1,0,1 at edges N..N+3, T_OUT=1 over the same edges. Q=0, T_OUT=0, BUSY=0 at N+4.
- Back-to-back: 4'hA then 4'h5 with DATA_VALID held -> second word accepted exactly at the edge where READY=1 (counter=3). Q=0,1,0,1,1,0,1,0 contiguous, T_OUT never drops.
- Stall/hold: DATA_VALID=1 during mid-word (READY=0) with D changing 4'h3->4'hC -> ignored. 4'hC is taken at the next READY edge and the current word is unaffected.
- Tristate word: D=4'hF, OE_IN=0 -> T_OUT=0 for all 4 bit cycles, BUSY=1 for 4 cycles.
- Reset mid-word: RST low at bit 2 of 4'h9 -> Q, T_OUT, BUSY drop asynchronously. After release, idle with Q=IDLE_VALUE.
- With IO_TX_PARITY_EN: D=4'b0111 -> Q=1,1,1,0 then parity 1; 5-cycle frame, READY high only on the parity cycle.

Source files
------------

// File: rtl/io_tx_serializer_if.sv
// io_tx_serializer_if: valid/ready word handshake from fabric into the TX serializer.
interface io_tx_serializer_if #(parameter int WIDTH = 4);
    logic [WIDTH-1:0] D;
    logic             DATA_VALID;
    logic             OE_IN;
    logic             READY;
    modport master (output D, DATA_VALID, OE_IN, input READY);
    modport slave  (input D, DATA_VALID, OE_IN, output READY);
endinterface

// File: rtl/io_tx_serializer.sv
// io_tx_serializer: parallel-to-serial TX gearbox feeding O_BUFT (Q + registered T_OUT, LSB first).
// Define IO_TX_PARITY_EN to append an even-parity bit to every word.
module io_tx_serializer #(
    parameter int   WIDTH      = 4,
    parameter logic IDLE_VALUE = 1'b0
) (
    input  logic                CLK,
    input  logic                RST,
    io_tx_serializer_if.slave   bus,
    output logic                Q,
    output logic                T_OUT,
    output logic                BUSY
);
    localparam int CW = $clog2(WIDTH + 1);
`ifdef IO_TX_PARITY_EN
    localparam int LAST = WIDTH;
    logic par;
    assign par = ^bus.D;
`else
    localparam int LAST = WIDTH - 1;
    logic par;
    assign par = 1'b0;
`endif
    typedef enum logic {IDLE, SHIFT} state_t;
    state_t           state, state_n;
    logic [CW-1:0]    cnt, cnt_n;
    logic [WIDTH-1:0] sr, sr_n;
    logic             q_n, t_n, last, xfer;
    assign last      = (state == SHIFT) && (cnt == CW'(LAST));
    assign bus.READY = (state == IDLE) || last;
    assign xfer      = bus.DATA_VALID && bus.READY;
    assign BUSY      = (state == SHIFT);
    always_ff @(posedge CLK or negedge RST)
        if (!RST) begin
            state <= IDLE;
            cnt   <= '0;
            sr    <= '0;
            Q     <= IDLE_VALUE;
            T_OUT <= 1'b0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            sr    <= sr_n;
            Q     <= q_n;
            T_OUT <= t_n;
        end
    // The remaining bits (and parity, if enabled) sit in sr and drain LSB first.
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        sr_n    = sr;
        q_n     = Q;
        t_n     = T_OUT;
        if (xfer) begin
            state_n = SHIFT;
            cnt_n   = '0;
            sr_n    = {par, bus.D[WIDTH-1:1]};
            q_n     = bus.D[0];
            t_n     = bus.OE_IN;
        end else if (last) begin
            state_n = IDLE;
            cnt_n   = '0;
            sr_n    = '0;
            q_n     = IDLE_VALUE;
            t_n     = 1'b0;
        end else if (state == SHIFT) begin
            cnt_n = cnt + CW'(1);
            sr_n  = sr >> 1;
            q_n   = sr[0];
        end
    end
endmodule

// File: tb/tb_io_tx_serializer.sv
// tb_io_tx_serializer: directed vectors with hand-computed serial streams for WIDTH=4.
module tb_io_tx_serializer;
    logic CLK = 1'b0;
    logic RST = 1'b0;
    logic Q, T_OUT, BUSY;
    int   n_cmp = 0;
    int   n_err = 0;
    io_tx_serializer_if #(.WIDTH(4)) bus ();
    io_tx_serializer #(.WIDTH(4), .IDLE_VALUE(1'b0)) dut (
        .CLK(CLK), .RST(RST), .bus(bus.slave), .Q(Q), .T_OUT(T_OUT), .BUSY(BUSY)
    );
    always #5 CLK = ~CLK;
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask
    task automatic step();
        @(posedge CLK);
        #1;
    endtask
    task automatic idle_chk(input string tag);
        chk({tag, "_q"}, Q, 0);
        chk({tag, "_t"}, T_OUT, 0);
        chk({tag, "_busy"}, BUSY, 0);
    endtask
    logic [7:0] seq;
    initial begin
        bus.D = 4'hF;
        bus.DATA_VALID = 1'b1;
        bus.OE_IN = 1'b1;
        for (int i = 0; i < 2; i++) begin
            step();
            idle_chk("rst_hold");
        end
        bus.DATA_VALID = 1'b0;
        RST = 1'b1;
        step();
        idle_chk("rst_release");
        chk("rst_ready", bus.READY, 1);
        // single word 1011 -> 1,1,0,1
        bus.D = 4'b1011; bus.OE_IN = 1'b1; bus.DATA_VALID = 1'b1;
        seq = 8'b0000_1011;
        step();
        bus.DATA_VALID = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk("single_q", Q, seq[i]);
            chk("single_t", T_OUT, 1);
            chk("single_busy", BUSY, 1);
            chk("single_ready", bus.READY, i == 3);
            if (i < 3) step();
        end
        step();
        idle_chk("single_end");
        // back-to-back A then 5 -> 0,1,0,1,1,0,1,0
        bus.D = 4'hA; bus.DATA_VALID = 1'b1;
        step();
        bus.D = 4'h5;
        seq = 8'b0101_1010;
        for (int i = 0; i < 8; i++) begin
            if (i == 4) bus.DATA_VALID = 1'b0;
            chk("b2b_q", Q, seq[i]);
            chk("b2b_t", T_OUT, 1);
            chk("b2b_ready", bus.READY, (i % 4) == 3);
            if (i < 7) step();
        end
        step();
        idle_chk("b2b_end");
        // stall: D changes 3 -> C while READY=0 -> 1,1,0,0,0,0,1,1
        bus.D = 4'h3; bus.DATA_VALID = 1'b1;
        step();
        bus.D = 4'hC;
        seq = 8'b1100_0011;
        for (int i = 0; i < 8; i++) begin
            if (i == 4) bus.DATA_VALID = 1'b0;
            chk("stall_q", Q, seq[i]);
            chk("stall_busy", BUSY, 1);
            if (i < 7) step();
        end
        step();
        idle_chk("stall_end");
        // tristated word
        bus.D = 4'hF; bus.OE_IN = 1'b0; bus.DATA_VALID = 1'b1;
        step();
        bus.DATA_VALID = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk("tri_q", Q, 1);
            chk("tri_t", T_OUT, 0);
            chk("tri_busy", BUSY, 1);
            if (i < 3) step();
        end
        step();
        idle_chk("tri_end");
        // reset at bit 2 of 1001
        bus.D = 4'h9; bus.OE_IN = 1'b1; bus.DATA_VALID = 1'b1;
        step();
        bus.DATA_VALID = 1'b0;
        chk("mrst_q0", Q, 1);
        step();
        step();
        chk("mrst_t2", T_OUT, 1);
        chk("mrst_busy2", BUSY, 1);
        #2 RST = 1'b0;
        #1;
        idle_chk("mrst_async");
        step();
        step();
        RST = 1'b1;
        step();
        idle_chk("mrst_after");
        step();
        idle_chk("mrst_after2");
        chk("mrst_ready", bus.READY, 1);
`ifdef IO_TX_PARITY_EN
        // 0111 -> 1,1,1,0 then parity 1
        bus.D = 4'b0111; bus.OE_IN = 1'b1; bus.DATA_VALID = 1'b1;
        seq = 8'b0001_0111;
        step();
        bus.DATA_VALID = 1'b0;
        for (int i = 0; i < 5; i++) begin
            chk("par_q", Q, seq[i]);
            chk("par_t", T_OUT, 1);
            chk("par_ready", bus.READY, i == 4);
            if (i < 4) step();
        end
        step();
        idle_chk("par_end");
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
